mult_share_arbiter: RTL and testbench

//  Shares one combinational WIDTHxWIDTH array multiplier among NREQ requesters.

---
 rtl/mult_share_arbiter.sv | 119 +++++++++++
 tb/tb_mult_share_arbiter.sv | 194 +++++++++++++++++++
 2 files changed

// File: rtl/mult_share_arbiter.sv
// Round-robin arbiter sharing one external array multiplier among NREQ clients.
// Operands are registered at grant, held SETTLE cycles, then the product is captured.
module mult_share_arbiter #(
   parameter int NREQ   = 2,
   parameter int WIDTH  = 4,
   parameter int SETTLE = 1
) (
   input  logic                    clk,
   input  logic                    rst_n,
   input  logic [NREQ-1:0]         req,
   input  logic [NREQ*WIDTH-1:0]   a_flat,
   input  logic [NREQ*WIDTH-1:0]   b_flat,
   output logic [NREQ-1:0]         grant,
   output logic [NREQ-1:0]         done,
   output logic [2*WIDTH-1:0]      result,
   output logic                    busy,
   output logic [WIDTH-1:0]        mul_a,
   output logic [WIDTH-1:0]        mul_b,
   input  logic [2*WIDTH-1:0]      mul_p
);

   localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
   localparam int CW = (SETTLE > 1) ? $clog2(SETTLE) : 1;
   localparam logic [NREQ-1:0] ONE = NREQ'(1);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t             state, state_nx;
   logic [IW-1:0]      ptr, ptr_nx;
   logic [IW-1:0]      idx, idx_nx;
   logic [CW-1:0]      cnt, cnt_nx;
   logic [NREQ-1:0]    grant_nx, done_nx;
   logic [2*WIDTH-1:0] result_nx;
   logic [WIDTH-1:0]   mul_a_nx, mul_b_nx;
   logic               found;
   logic [IW-1:0]      win;

   // First set request at or after ptr, wrapping around.
   always_comb begin
      int j;
      found = 1'b0;
      win   = '0;
      j     = 0;
      for (int k = 0; k < NREQ; k++) begin
         j = int'(ptr) + k;
         if (j >= NREQ) j = j - NREQ;
         if (!found && req[j]) begin
            found = 1'b1;
            win   = IW'(j);
         end
      end
   end

   always_comb begin
      state_nx  = state;
      ptr_nx    = ptr;
      idx_nx    = idx;
      cnt_nx    = cnt;
      grant_nx  = grant;
      done_nx   = done;
      result_nx = result;
      mul_a_nx  = mul_a;
      mul_b_nx  = mul_b;
      unique case (state)
         IDLE: begin
            if (found) begin
               idx_nx   = win;
               grant_nx = ONE << win;
               mul_a_nx = a_flat[win*WIDTH +: WIDTH];
               mul_b_nx = b_flat[win*WIDTH +: WIDTH];
               cnt_nx   = '0;
               state_nx = WAIT;
            end
         end
         WAIT: begin
            cnt_nx = cnt + 1'b1;
            if (cnt == CW'(SETTLE - 1)) begin
               result_nx = mul_p;
               done_nx   = ONE << idx;
               grant_nx  = '0;
               ptr_nx    = (idx == IW'(NREQ - 1)) ? '0 : idx + 1'b1;
               state_nx  = DONE;
            end
         end
         DONE: begin
            done_nx  = '0;
            state_nx = IDLE;
         end
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state  <= IDLE;
         ptr    <= '0;
         idx    <= '0;
         cnt    <= '0;
         grant  <= '0;
         done   <= '0;
         result <= '0;
         mul_a  <= '0;
         mul_b  <= '0;
      end else begin
         state  <= state_nx;
         ptr    <= ptr_nx;
         idx    <= idx_nx;
         cnt    <= cnt_nx;
         grant  <= grant_nx;
         done   <= done_nx;
         result <= result_nx;
         mul_a  <= mul_a_nx;
         mul_b  <= mul_b_nx;
      end
   end

   assign busy = (state != IDLE);

endmodule

// File: tb/tb_mult_share_arbiter.sv
// Directed + random bench for mult_share_arbiter against a transaction-level
// round-robin / product reference model.
module tb_mult_share_arbiter;

   localparam int NREQ   = 2;
   localparam int WIDTH  = 4;
   localparam int SETTLE = 1;

   logic                  clk;
   logic                  rst_n;
   logic [NREQ-1:0]       req;
   logic [NREQ*WIDTH-1:0] a_flat;
   logic [NREQ*WIDTH-1:0] b_flat;
   logic [NREQ-1:0]       grant;
   logic [NREQ-1:0]       done;
   logic [2*WIDTH-1:0]    result;
   logic                  busy;
   logic [WIDTH-1:0]      mul_a;
   logic [WIDTH-1:0]      mul_b;
   logic [2*WIDTH-1:0]    mul_p;

   int vectors    = 0;
   int miscompares = 0;
   int ptr_m      = 0;

   mult_share_arbiter #(
      .NREQ(NREQ), .WIDTH(WIDTH), .SETTLE(SETTLE)
   ) dut (
      .clk(clk), .rst_n(rst_n), .req(req),
      .a_flat(a_flat), .b_flat(b_flat),
      .grant(grant), .done(done), .result(result), .busy(busy),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p)
   );

   // external 4x4 array multiplier
   assign mul_p = mul_a * mul_b;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs,
                      input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: got %0h want %0h", tag, obs, exp);
      end
   endtask

   function automatic int pick(input logic [NREQ-1:0] r);
      for (int k = 0; k < NREQ; k++) begin
         int j;
         j = (ptr_m + k) % NREQ;
         if (r[j]) return j;
      end
      return -1;
   endfunction

   // One transaction from IDLE; keep=1 leaves req asserted, mess=1 disturbs
   // operands and drops req during WAIT.
   task automatic do_op(input logic [1:0] r,
                        input logic [3:0] a0, input logic [3:0] b0,
                        input logic [3:0] a1, input logic [3:0] b1,
                        input bit keep, input bit mess);
      int w;
      int n;
      logic [3:0] ea, eb;
      logic [7:0] ep;
      req    = r;
      a_flat = {a1, a0};
      b_flat = {b1, b0};
      w = pick(r);
      if (w < 0) begin
         @(negedge clk);
         chk("idle_grant", grant, 0);
         chk("idle_busy", busy, 0);
         return;
      end
      ea = (w == 1) ? a1 : a0;
      eb = (w == 1) ? b1 : b0;
      ep = ea * eb;
      @(negedge clk);
      chk("grant", grant, 1 << w);
      chk("busy_wait", busy, 1);
      chk("mul_a", mul_a, ea);
      chk("mul_b", mul_b, eb);
      chk("done_early", done, 0);
      if (mess) begin
         a_flat = a_flat ^ 8'hFF;
         b_flat = b_flat ^ 8'h5A;
         req    = '0;
      end
      n = 0;
      while (done == '0 && n < 8) begin
         @(negedge clk);
         n++;
      end
      chk("latency", n, SETTLE);
      chk("done", done, 1 << w);
      chk("result", result, ep);
      chk("grant_at_done", grant, 0);
      chk("mul_a_held", mul_a, ea);
      ptr_m = (w + 1) % NREQ;
      if (!keep) req[w] = 1'b0;
      @(negedge clk);
      chk("done_clear", done, 0);
      chk("busy_idle", busy, 0);
      chk("result_held", result, ep);
   endtask

   initial begin
      rst_n  = 1'b0;
      req    = '0;
      a_flat = '0;
      b_flat = '0;
      #1;
      chk("rst_grant", grant, 0);
      chk("rst_done", done, 0);
      chk("rst_result", result, 0);
      chk("rst_busy", busy, 0);
      chk("rst_mul_a", mul_a, 0);
      chk("rst_mul_b", mul_b, 0);
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // single requester, 3*5
      do_op(2'b01, 4'd3, 4'd5, 4'd0, 4'd0, 0, 0);
      chk("t1_result", result, 8'h0F);

      // fresh reset, then both request
      rst_n = 1'b0;
      ptr_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_op(2'b11, 4'd2, 4'd7, 4'd9, 4'd4, 0, 0);
      chk("t2_first", result, 8'd14);
      do_op(2'b11, 4'd2, 4'd7, 4'd9, 4'd4, 0, 0);
      chk("t2_second", result, 8'd36);

      // held requests rotate
      for (int i = 0; i < 4; i++)
         do_op(2'b11, 4'd6, 4'd3, 4'd11, 4'd13, 1, 0);

      // extremes
      do_op(2'b10, 4'd0, 4'd0, 4'd15, 4'd15, 0, 0);
      chk("t4_max", result, 8'hE1);
      do_op(2'b10, 4'd0, 4'd0, 4'd0, 4'd9, 0, 0);
      chk("t4_zero", result, 8'h00);

      // operands change and req drops mid-op
      do_op(2'b01, 4'd7, 4'd6, 4'd1, 4'd1, 0, 1);
      chk("t5_orig", result, 8'd42);

      // random traffic
      for (int i = 0; i < 60; i++)
         do_op(2'($urandom_range(0, 3)),
               4'($urandom), 4'($urandom),
               4'($urandom), 4'($urandom),
               1'($urandom_range(0, 1)), 1'($urandom_range(0, 4) == 0));

      // reset during WAIT
      req    = 2'b10;
      a_flat = {4'd5, 4'd0};
      b_flat = {4'd5, 4'd0};
      @(negedge clk);
      chk("t6_granted", grant, 2'b10);
      rst_n = 1'b0;
      req   = '0;
      #1;
      chk("t6_grant", grant, 0);
      chk("t6_done", done, 0);
      chk("t6_result", result, 0);
      chk("t6_mul_a", mul_a, 0);
      chk("t6_mul_b", mul_b, 0);
      chk("t6_busy", busy, 0);
      ptr_m = 0;
      @(negedge clk);
      rst_n = 1'b1;
      for (int i = 0; i < 3; i++) begin
         @(negedge clk);
         chk("t6_no_done", done, 0);
      end
      do_op(2'b11, 4'd4, 4'd4, 4'd8, 4'd8, 0, 0);
      chk("t6_restart", result, 8'd16);

      $display("== %0d vectors applied, %0d miscompares ==",
               vectors, miscompares);
      $finish;
   end

endmodule
